// File: rtl/fcmp_pipe.sv
// Two-stage pipelined FP compare (feq/flt/fle) with valid/ready on both sides.
// Define FCMP_FLAGS_EN to build the invalid-operation flag path and out_nv port.
module fcmp_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
`ifdef FCMP_FLAGS_EN
    output logic             out_nv,
`endif
    output logic             busy
);

    logic             s1_v;
    logic [1:0]       s1_op;
    logic [31:0]      s1_x1;
    logic [31:0]      s1_x2;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_v;
    logic             s2_cmp;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_adv;
    logic             s2_adv;

    logic [30:0]      m1;
    logic [30:0]      m2;
    logic             sg1;
    logic             sg2;
    logic             nan1;
    logic             nan2;
    logic             eq;
    logic             lt;
    logic             cmp;

    assign s2_adv   = !s2_v || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;
    assign busy     = s1_v || s2_v;

    // Zero exponent flushes to +0 so that +0/-0 and denormals compare equal.
    always_comb begin
        m1   = (s1_x1[30:23] == 8'd0) ? 31'd0 : s1_x1[30:0];
        m2   = (s1_x2[30:23] == 8'd0) ? 31'd0 : s1_x2[30:0];
        sg1  = s1_x1[31] && (m1 != 31'd0);
        sg2  = s1_x2[31] && (m2 != 31'd0);
        nan1 = (&s1_x1[30:23]) && (|s1_x1[22:0]);
        nan2 = (&s1_x2[30:23]) && (|s1_x2[22:0]);
        eq   = (m1 == m2) && (sg1 == sg2);
        if (sg1 != sg2) begin
            lt = sg1;
        end else if (sg1) begin
            lt = m1 > m2;
        end else begin
            lt = m1 < m2;
        end
        case (s1_op)
            2'b00:   cmp = !(nan1 || nan2) && eq;
            2'b01:   cmp = !(nan1 || nan2) && lt;
            2'b10:   cmp = !(nan1 || nan2) && (lt || eq);
            default: cmp = 1'b0;
        endcase
    end

`ifdef FCMP_FLAGS_EN
    logic s2_nv;
    logic nv;

    // feq signals only on signalling NaN; ordered compares on any NaN.
    always_comb begin
        case (s1_op)
            2'b00:   nv = (nan1 && !s1_x1[22]) || (nan2 && !s1_x2[22]);
            2'b01:   nv = nan1 || nan2;
            2'b10:   nv = nan1 || nan2;
            default: nv = 1'b0;
        endcase
    end

    assign out_nv = s2_nv;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v   <= 1'b0;
            s1_op  <= 2'b00;
            s1_x1  <= 32'd0;
            s1_x2  <= 32'd0;
            s1_tag <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_x1  <= in_x1;
                s1_x2  <= in_x2;
                s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_v   <= 1'b0;
            s2_cmp <= 1'b0;
            s2_tag <= '0;
`ifdef FCMP_FLAGS_EN
            s2_nv  <= 1'b0;
`endif
        end else if (flush) begin
            s2_v <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_cmp <= cmp;
                s2_tag <= s1_tag;
`ifdef FCMP_FLAGS_EN
                s2_nv  <= nv;
`endif
            end
        end
    end

    assign out_valid  = s2_v;
    assign out_result = {31'd0, s2_cmp};
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: real-valued compare model, randomized
// operands and back-pressure, flush and mid-stream reset.
module tb_fcmp_pipe;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [31:0]      in_x1 = 32'd0;
    logic [31:0]      in_x2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef FCMP_FLAGS_EN
    logic             out_nv;
`endif
    logic             busy;

    typedef struct packed {
        logic             cmp;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   chk_rdy = 1'b0;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
`ifdef FCMP_FLAGS_EN
        .out_nv    (out_nv),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference model: value of the float as a real, flushed/saturated.
    function automatic real fval(input logic [31:0] x);
        logic [7:0] e;
        real        m;
        e = x[30:23];
        if (e == 8'd0) return 0.0;
        if (e == 8'hFF) begin
            m = 1.0e300;
        end else begin
            m = 1.0 + real'(x[22:0]) / 8388608.0;
            m = m * (2.0 ** (real'(e) - 127.0));
        end
        return x[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit model_cmp(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        real ra;
        real rb;
        if (is_nan(a) || is_nan(b)) return 1'b0;
        ra = fval(a);
        rb = fval(b);
        case (op)
            2'b00:   return ra == rb;
            2'b01:   return ra < rb;
            2'b10:   return ra <= rb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_nv(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        bit na;
        bit nb;
        na = is_nan(a);
        nb = is_nan(b);
        case (op)
            2'b00:   return (na && !a[22]) || (nb && !b[22]);
            2'b01:   return na || nb;
            2'b10:   return na || nb;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: a result transfers on the edge following this sample.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got tag %0h want none",
                         out_tag);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_result", 64'(out_result), 64'({31'd0, e.cmp}));
                check("out_tag", 64'(out_tag), 64'(e.tag));
`ifdef FCMP_FLAGS_EN
                check("out_nv", 64'(out_nv), 64'(e.nv));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_rdy) check("in_ready_b2b", 64'(in_ready), 64'd1);
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom % 4) != 0;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = t;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back('{cmp: model_cmp(op, a, b),
                                nv: model_nv(op, a, b), tag: t});
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready 0 want 1");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 || busy) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: got %0d pending want 0",
                         sbq.size());
                break;
            end
        end
    endtask

    function automatic logic [31:0] rnd_normal();
        logic [31:0] x;
        x        = $urandom;
        x[30:23] = 8'($urandom_range(1, 254));
        return x;
    endfunction

    function automatic logic [31:0] rnd_special();
        logic [31:0] pool [12];
        pool = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h80000005,
                 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'h40000000};
        if ($urandom_range(0, 3) == 0) return rnd_normal();
        return pool[$urandom_range(0, 11)];
    endfunction

    initial begin
        int          c0;
        logic [31:0] a;
        logic [31:0] b;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef FCMP_FLAGS_EN
        check("rst_out_nv", 64'(out_nv), 64'd0);
`endif
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: result visible after the second edge, then gone.
        out_ready = 1'b1;
        send(2'b01, 32'h3F800000, 32'h40000000, 5'd7);
        check("lat_early_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_result", 64'(out_result), 64'd1);
        check("lat_tag", 64'(out_tag), 64'd7);
        @(posedge clk);
        #1;
        check("lat_valid_drop", 64'(out_valid), 64'd0);

        send(2'b00, 32'h80000000, 32'h00000000, 5'd1);
        send(2'b00, 32'h00000001, 32'h00000000, 5'd2);
        send(2'b10, 32'hBF800000, 32'hBF800000, 5'd3);
        wait_drain();

        // Back-to-back normals must stream without a bubble.
        c0 = cyc;
        chk_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = rnd_normal();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {a[31:23], 23'($urandom)};
                default: b = rnd_normal();
            endcase
            send(2'($urandom_range(0, 2)), a, b, 5'(i));
        end
        chk_rdy = 1'b0;
        wait_drain();
        check("b2b_cycles_le18", 64'((cyc - c0) <= 18), 64'd1);

        // Back-pressure: two accepted, third held until release.
        out_ready = 1'b0;
        send(2'b01, 32'h3F800000, 32'h40000000, 5'd10);
        send(2'b00, 32'h3F800000, 32'h40000000, 5'd11);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_tag", 64'(out_tag), 64'd10);
            check("bp_out_result", 64'(out_result), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2'b10, 32'h40000000, 32'h3F800000, 5'd12);
        wait_drain();

        // Flush with two ops in flight and a fresh request offered.
        out_ready = 1'b0;
        send(2'b00, 32'h3F800000, 32'h3F800000, 5'd20);
        send(2'b00, 32'h3F800000, 32'h3F800000, 5'd21);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd22;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("flush_quiet", 64'(out_valid), 64'd0);
        end

        // Randomized specials with random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(2'($urandom_range(0, 3)), rnd_special(), rnd_special(),
                 5'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

`ifdef FCMP_FLAGS_EN
        send(2'b01, 32'h7FC00000, 32'h3F800000, 5'd4);
        send(2'b00, 32'h7FC00000, 32'h3F800000, 5'd5);
        send(2'b00, 32'h7F800001, 32'h3F800000, 5'd6);
        wait_drain();
`endif

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        send(2'b10, 32'h3F800000, 32'h40000000, 5'd25);
        send(2'b10, 32'h3F800000, 32'h40000000, 5'd26);
        #2;
        rstn = 1'b0;
        #1;
        sbq.delete();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_result", 64'(out_result), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
`ifdef FCMP_FLAGS_EN
        check("arst_out_nv", 64'(out_nv), 64'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        send(2'b01, 32'hC0000000, 32'h3F800000, 5'd27);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
